mac_result_checker: RTL

- Hardware consumer for the MAC output interface (f, valid_out). It is the receiving end of the stream that the MAC produces.
- Holds a RAM of expected results, loaded through a write port before or during a run.
- Compares each valid MAC output beat, in order, against that RAM.
- Reports match/mismatch counts, the first-error record, and a pass/done status. Used for on-chip self-check of the MAC datapath in place of file-based benches.

---
 rtl/mac_result_checker.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_result_checker.sv
// On-chip consumer of the MAC (f, valid_out) stream: compares each beat in order against a
// RAM of expected results. Optional macro MAC_CHECK_STRAY_COUNT_EN adds a stray-beat counter.
module mac_result_checker #(
    parameter int OUT_WIDTH = 20,
    parameter int DEPTH     = 256,
    parameter int CNT_WIDTH = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exp_wr_en,
    input  logic [AW-1:0]        exp_wr_addr,
    input  logic [OUT_WIDTH-1:0] exp_wr_data,
    input  logic [AW:0]          num_expected,
    input  logic                 start,
    input  logic [OUT_WIDTH-1:0] mac_f,
    input  logic                 mac_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic [CNT_WIDTH-1:0] mismatch_count,
    output logic                 err_flag,
    output logic [AW-1:0]        first_err_idx,
    output logic [OUT_WIDTH-1:0] first_err_got,
`ifdef MAC_CHECK_STRAY_COUNT_EN
    output logic [CNT_WIDTH-1:0] stray_count,
`endif
    output logic [OUT_WIDTH-1:0] first_err_exp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]          DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [OUT_WIDTH-1:0] r_mem [DEPTH];

    state_t               r_state, w_state_nxt;
    logic [AW-1:0]        r_rd_ptr, w_rd_ptr_nxt;
    logic [AW:0]          r_target, w_target_nxt;
    logic [CNT_WIDTH-1:0] r_match, w_match_nxt;
    logic [CNT_WIDTH-1:0] r_mismatch, w_mismatch_nxt;
    logic                 r_err, w_err_nxt;
    logic [AW-1:0]        r_err_idx, w_err_idx_nxt;
    logic [OUT_WIDTH-1:0] r_err_got, w_err_got_nxt;
    logic [OUT_WIDTH-1:0] r_err_exp, w_err_exp_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_pass, w_pass_nxt;
    logic                 w_stray_ok_nxt;
`ifdef MAC_CHECK_STRAY_COUNT_EN
    logic [CNT_WIDTH-1:0] r_stray, w_stray_nxt;
`endif

    logic [OUT_WIDTH-1:0] w_exp;
    logic [AW:0]          w_clamped;
    logic [AW:0]          w_consumed;

    assign w_exp      = r_mem[r_rd_ptr];
    assign w_clamped  = (num_expected > DEPTH_C) ? DEPTH_C : num_expected;
    assign w_consumed = {1'b0, r_rd_ptr} + (AW+1)'(1);

    // Expected-result RAM; a same-cycle compare sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (exp_wr_en) begin
            r_mem[exp_wr_addr] <= exp_wr_data;
        end else begin
            r_mem[exp_wr_addr] <= r_mem[exp_wr_addr];
        end
    end

    // Next-state and next-status computation.
    always_comb begin
        w_state_nxt    = r_state;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_target_nxt   = r_target;
        w_match_nxt    = r_match;
        w_mismatch_nxt = r_mismatch;
        w_err_nxt      = r_err;
        w_err_idx_nxt  = r_err_idx;
        w_err_got_nxt  = r_err_got;
        w_err_exp_nxt  = r_err_exp;
        w_pass_nxt     = 1'b0;
`ifdef MAC_CHECK_STRAY_COUNT_EN
        w_stray_nxt    = r_stray;
        if (mac_valid && (r_state != S_RUN) && (r_stray != CNT_MAX)) begin
            w_stray_nxt = r_stray + CNT_WIDTH'(1);
        end else begin
            w_stray_nxt = r_stray;
        end
        w_stray_ok_nxt = (w_stray_nxt == {CNT_WIDTH{1'b0}});
`else
        w_stray_ok_nxt = 1'b1;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_target_nxt   = w_clamped;
                    w_rd_ptr_nxt   = {AW{1'b0}};
                    w_match_nxt    = {CNT_WIDTH{1'b0}};
                    w_mismatch_nxt = {CNT_WIDTH{1'b0}};
                    w_err_nxt      = 1'b0;
                    w_err_idx_nxt  = {AW{1'b0}};
                    w_err_got_nxt  = {OUT_WIDTH{1'b0}};
                    w_err_exp_nxt  = {OUT_WIDTH{1'b0}};
                    w_state_nxt    = (w_clamped == {(AW+1){1'b0}}) ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RUN: begin
                if (mac_valid) begin
                    if (mac_f == w_exp) begin
                        w_match_nxt = (r_match == CNT_MAX) ? r_match : r_match + CNT_WIDTH'(1);
                    end else begin
                        w_mismatch_nxt = (r_mismatch == CNT_MAX) ? r_mismatch
                                                                 : r_mismatch + CNT_WIDTH'(1);
                        if (!r_err) begin
                            w_err_nxt     = 1'b1;
                            w_err_idx_nxt = r_rd_ptr;
                            w_err_got_nxt = mac_f;
                            w_err_exp_nxt = w_exp;
                        end else begin
                            w_err_nxt = r_err;
                        end
                    end
                    w_rd_ptr_nxt = r_rd_ptr + AW'(1);
                    w_state_nxt  = (w_consumed == r_target) ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_RUN);
        w_done_nxt = (w_state_nxt == S_DONE);
        // pass is evaluated on DONE entry (including a re-arm straight back into DONE), then held.
        if (w_state_nxt == S_DONE) begin
            if ((r_state != S_DONE) || start) begin
                w_pass_nxt = (w_mismatch_nxt == {CNT_WIDTH{1'b0}}) && w_stray_ok_nxt;
            end else begin
                w_pass_nxt = r_pass;
            end
        end else begin
            w_pass_nxt = 1'b0;
        end
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rd_ptr   <= {AW{1'b0}};
            r_target   <= {(AW+1){1'b0}};
            r_match    <= {CNT_WIDTH{1'b0}};
            r_mismatch <= {CNT_WIDTH{1'b0}};
            r_err      <= 1'b0;
            r_err_idx  <= {AW{1'b0}};
            r_err_got  <= {OUT_WIDTH{1'b0}};
            r_err_exp  <= {OUT_WIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
`ifdef MAC_CHECK_STRAY_COUNT_EN
            r_stray    <= {CNT_WIDTH{1'b0}};
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_target   <= w_target_nxt;
            r_match    <= w_match_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_err      <= w_err_nxt;
            r_err_idx  <= w_err_idx_nxt;
            r_err_got  <= w_err_got_nxt;
            r_err_exp  <= w_err_exp_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
`ifdef MAC_CHECK_STRAY_COUNT_EN
            r_stray    <= w_stray_nxt;
`endif
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign match_count    = r_match;
    assign mismatch_count = r_mismatch;
    assign err_flag       = r_err;
    assign first_err_idx  = r_err_idx;
    assign first_err_got  = r_err_got;
    assign first_err_exp  = r_err_exp;
`ifdef MAC_CHECK_STRAY_COUNT_EN
    assign stray_count    = r_stray;
`endif

endmodule
